// File: rtl/pmodenc_pkg.sv
// pmodenc_pkg: shared state encoding, tick computation and event_status bit indices
// for the PmodENC peripheral.
package pmodenc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        LONG_HELD,
        WAIT2,
        PRESS2
    } state_e;

    localparam int EV_SHORT  = 0;
    localparam int EV_LONG   = 1;
    localparam int EV_DOUBLE = 2;

    function automatic int unsigned tick_clocks(input int unsigned freq_hz, input int unsigned simulate);
        return (simulate == 0) ? freq_hz / 1000 : 5;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: millisecond prescaler, one tick every TICK clocks.
// restart forces the count back to 0 so the first tick arrives TICK clocks later.
module ms_tick_gen #(
    parameter int unsigned TICK = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int W = (TICK > 1) ? $clog2(TICK) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    assign tick  = cnt_q == W'(TICK - 1);
    assign cnt_d = (restart || tick) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/button_event_detector.sv
// button_event_detector: classifies the debounced button level into press/release
// edges and short/long/double-click events with sticky status flags.
module button_event_detector
    import pmodenc_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ_HZ   = 100000000,
    parameter int unsigned LONG_PRESS_MS   = 1000,
    parameter int unsigned DOUBLE_CLICK_MS = 300,
    parameter int unsigned SIMULATE        = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       BTN_in,
    input  logic       clr_events,
    output logic       btn_state,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       short_press,
    output logic       long_press,
    output logic       double_click,
    output logic [2:0] event_status
);

    localparam int unsigned TICK = tick_clocks(CLOCK_FREQ_HZ, SIMULATE);

    state_e      state_q, state_d;
    logic        btn_q, press_q, release_q;
    logic        rise, fall, tick, restart, long_hit, dbl_hit;
    logic [2:0]  ev_d, ev_q, status_d, status_q;
    logic [15:0] ms_cnt_q, ms_cnt_d;

    ms_tick_gen #(.TICK(TICK)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .restart(restart),
        .tick   (tick)
    );

    assign rise     = BTN_in & ~btn_q;
    assign fall     = ~BTN_in & btn_q;
    assign long_hit = ms_cnt_q == 16'(LONG_PRESS_MS);
    assign dbl_hit  = ms_cnt_q == 16'(DOUBLE_CLICK_MS);

    // Competing edge and timeout: the timeout always takes priority.
    always_comb begin
        state_d = state_q;
        ev_d    = '0;
        case (state_q)
            IDLE:      if (rise) state_d = PRESSED;
            PRESSED: begin
                if (long_hit) begin
                    ev_d[EV_LONG] = 1'b1;
                    state_d       = fall ? IDLE : LONG_HELD;
                end else if (fall) begin
                    state_d = WAIT2;
                end
            end
            LONG_HELD: if (fall) state_d = IDLE;
            WAIT2: begin
                if (dbl_hit) begin
                    ev_d[EV_SHORT] = 1'b1;
                    state_d        = rise ? PRESSED : IDLE;
                end else if (rise) begin
                    ev_d[EV_DOUBLE] = 1'b1;
                    state_d         = PRESS2;
                end
            end
            PRESS2:    if (fall) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    assign restart  = state_d != state_q;
    assign ms_cnt_d = restart ? '0 : (tick && ms_cnt_q != 16'hFFFF) ? ms_cnt_q + 16'd1 : ms_cnt_q;
    // A flag is held through both the cycle its pulse is generated and the cycle it is visible.
    assign status_d = ev_d | ev_q | (status_q & {3{~clr_events}});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            btn_q     <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            ev_q      <= '0;
            status_q  <= '0;
            ms_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            btn_q     <= BTN_in;
            press_q   <= rise;
            release_q <= fall;
            ev_q      <= ev_d;
            status_q  <= status_d;
            ms_cnt_q  <= ms_cnt_d;
        end
    end

    assign btn_state     = btn_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign short_press   = ev_q[EV_SHORT];
    assign long_press    = ev_q[EV_LONG];
    assign double_click  = ev_q[EV_DOUBLE];
    assign event_status  = status_q;

endmodule

// File: tb/tb_button_event_detector.sv
// tb_button_event_detector: cycle-by-cycle vector table for the event classifier
// with TICK=5, long press 4 ms, double-click window 3 ms.
module tb_button_event_detector;

    typedef struct {
        logic       btn;
        logic       clr;
        int         n;
        logic [8:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       BTN_in;
    logic       clr_events;
    logic       btn_state, press_pulse, release_pulse;
    logic       short_press, long_press, double_click;
    logic [2:0] event_status;
    logic [8:0] got;
    vec_t       tbl[$];
    int         checks = 0;
    int         errors = 0;

    button_event_detector #(
        .LONG_PRESS_MS  (4),
        .DOUBLE_CLICK_MS(3),
        .SIMULATE       (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .BTN_in       (BTN_in),
        .clr_events   (clr_events),
        .btn_state    (btn_state),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_click (double_click),
        .event_status (event_status)
    );

    always #5 clk = ~clk;

    // Output vector: {btn_state, press, release, short, long, double, status[2:0]}.
    assign got = {btn_state, press_pulse, release_pulse, short_press, long_press, double_click, event_status};

    task automatic chk(input string name, input logic [8:0] actual, input logic [8:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s got %b expected %b", name, actual, expected);
        end
    endtask

    task automatic add(input logic b, input logic c, input int n, input logic [8:0] e);
        vec_t v;
        v.btn = b;
        v.clr = c;
        v.n   = n;
        v.exp = e;
        tbl.push_back(v);
    endtask

    initial begin
        // short press: 8-cycle hold, short_press 16 cycles after release_pulse
        add(1, 0, 1,  9'b1_1_0_0_0_0_000);
        add(1, 0, 7,  9'b1_0_0_0_0_0_000);
        add(0, 0, 1,  9'b0_0_1_0_0_0_000);
        add(0, 0, 15, 9'b0_0_0_0_0_0_000);
        add(0, 0, 1,  9'b0_0_0_1_0_0_001);
        add(0, 0, 3,  9'b0_0_0_0_0_0_001);
        add(0, 1, 1,  9'b0_0_0_0_0_0_000);
        // long press: long_press 21 cycles after press_pulse, nothing on release
        add(1, 0, 1,  9'b1_1_0_0_0_0_000);
        add(1, 0, 20, 9'b1_0_0_0_0_0_000);
        add(1, 0, 1,  9'b1_0_0_0_1_0_010);
        add(1, 0, 18, 9'b1_0_0_0_0_0_010);
        add(0, 0, 1,  9'b0_0_1_0_0_0_010);
        add(0, 0, 20, 9'b0_0_0_0_0_0_010);
        add(0, 1, 1,  9'b0_0_0_0_0_0_000);
        // double click
        add(1, 0, 1,  9'b1_1_0_0_0_0_000);
        add(1, 0, 4,  9'b1_0_0_0_0_0_000);
        add(0, 0, 1,  9'b0_0_1_0_0_0_000);
        add(0, 0, 5,  9'b0_0_0_0_0_0_000);
        add(1, 0, 1,  9'b1_1_0_0_0_1_100);
        add(1, 0, 3,  9'b1_0_0_0_0_0_100);
        add(0, 0, 1,  9'b0_0_1_0_0_0_100);
        add(0, 0, 20, 9'b0_0_0_0_0_0_100);
        add(0, 1, 1,  9'b0_0_0_0_0_0_000);
        // second rise on the WAIT2 timeout cycle: short wins, then a fresh long press
        add(1, 0, 1,  9'b1_1_0_0_0_0_000);
        add(1, 0, 2,  9'b1_0_0_0_0_0_000);
        add(0, 0, 1,  9'b0_0_1_0_0_0_000);
        add(0, 0, 15, 9'b0_0_0_0_0_0_000);
        add(1, 0, 1,  9'b1_1_0_1_0_0_001);
        add(1, 0, 20, 9'b1_0_0_0_0_0_001);
        add(1, 0, 1,  9'b1_0_0_0_1_0_011);
        add(1, 0, 18, 9'b1_0_0_0_0_0_011);
        add(0, 0, 1,  9'b0_0_1_0_0_0_011);
        add(0, 0, 5,  9'b0_0_0_0_0_0_011);
        add(0, 1, 1,  9'b0_0_0_0_0_0_000);
        // clear coinciding with the long_press pulse: set wins
        add(1, 0, 1,  9'b1_1_0_0_0_0_000);
        add(1, 0, 20, 9'b1_0_0_0_0_0_000);
        add(1, 1, 1,  9'b1_0_0_0_1_0_010);
        add(1, 1, 1,  9'b1_0_0_0_0_0_010);
        add(1, 0, 5,  9'b1_0_0_0_0_0_010);
        add(0, 0, 1,  9'b0_0_1_0_0_0_010);
        add(0, 0, 3,  9'b0_0_0_0_0_0_010);
        add(0, 1, 1,  9'b0_0_0_0_0_0_000);
        add(0, 0, 2,  9'b0_0_0_0_0_0_000);

        reset      = 1'b1;
        BTN_in     = 1'b0;
        clr_events = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", got, 9'b0);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                BTN_in     = tbl[i].btn;
                clr_events = tbl[i].clr;
                @(posedge clk);
                #1;
                chk($sformatf("vec%0d.%0d", i, k), got, tbl[i].exp);
            end
        end
        clr_events = 1'b0;

        // asynchronous reset 10 cycles into a press
        BTN_in = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_press", got, 9'b1_1_0_0_0_0_000);
        repeat (9) @(posedge clk);
        #1;
        chk("rst_held", got, 9'b1_0_0_0_0_0_000);
        reset = 1'b1;
        #1;
        chk("rst_async", got, 9'b0);
        BTN_in = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rst_after.%0d", k), got, 9'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
